// File: rtl/tl_tx_fc_gate.sv
// Transmit flow-control gate: holds partner credit limits and local credits-consumed
// counters, and grants TLP requests using the modulo-2^N credit check.
module tl_tx_fc_gate #(
    parameter int CREDIT_DEPTH = 12,
    parameter int MAX_DCRED    = 16
) (
    input  logic                    sclk,
    input  logic                    srst,
    input  logic                    dl_up_i,
    input  logic [CREDIT_DEPTH-1:0] ep_cl_p_h_i,
    input  logic [CREDIT_DEPTH-1:0] ep_cl_p_d_i,
    input  logic [CREDIT_DEPTH-1:0] ep_cl_np_h_i,
    input  logic [CREDIT_DEPTH-1:0] ep_cl_cpl_h_i,
    input  logic [CREDIT_DEPTH-1:0] ep_cl_cpl_d_i,
    input  logic                    ep_cl_en_i,
    input  logic                    req_valid_i,
    input  logic [1:0]              req_type_i,
    input  logic [CREDIT_DEPTH-1:0] req_dcred_i,
    output logic                    req_ready_o,
    output logic [CREDIT_DEPTH-1:0] tx_cc_p_h_o,
    output logic [CREDIT_DEPTH-1:0] tx_cc_p_d_o,
    output logic [CREDIT_DEPTH-1:0] tx_cc_np_h_o,
    output logic [CREDIT_DEPTH-1:0] tx_cc_cpl_h_o,
    output logic [CREDIT_DEPTH-1:0] tx_cc_cpl_d_o,
    output logic                    fc_active_o,
    output logic                    fc_err_o
);

    localparam logic [CREDIT_DEPTH-1:0] HALF = {1'b1, {(CREDIT_DEPTH-1){1'b0}}};
    localparam logic [CREDIT_DEPTH-1:0] ONE  = {{(CREDIT_DEPTH-1){1'b0}}, 1'b1};
    localparam logic [CREDIT_DEPTH-1:0] DMAX = CREDIT_DEPTH'(MAX_DCRED);

    typedef enum logic {FC_INIT, FC_ACTIVE} state_t;
    state_t state, state_nxt;

    logic [CREDIT_DEPTH-1:0] cl_p_h, cl_p_d, cl_np_h, cl_cpl_h, cl_cpl_d;
    logic [CREDIT_DEPTH-1:0] cc_p_h, cc_p_d, cc_np_h, cc_cpl_h, cc_cpl_d;
    logic inf_p_h, inf_p_d, inf_np_h, inf_cpl_h, inf_cpl_d;
    logic is_p, is_np, is_cpl, legal, hdr_ok, dat_ok, xfer;

    // Wrapping distance from consumed+need up to the limit must stay within half range.
    function automatic logic credit_ok(input logic inf, input logic [CREDIT_DEPTH-1:0] cl,
                                       input logic [CREDIT_DEPTH-1:0] cc,
                                       input logic [CREDIT_DEPTH-1:0] need);
        logic [CREDIT_DEPTH-1:0] diff;
        diff = cl - (cc + need);
        return inf || (diff <= HALF);
    endfunction

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) state <= FC_INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        is_p        = (req_type_i == 2'd0);
        is_np       = (req_type_i == 2'd1);
        is_cpl      = (req_type_i == 2'd2);
        legal       = (is_p || is_np || is_cpl) && (is_np || (req_dcred_i <= DMAX));
        hdr_ok      = 1'b0;
        dat_ok      = 1'b1;
        if (is_p) begin
            hdr_ok = credit_ok(inf_p_h, cl_p_h, cc_p_h, ONE);
            dat_ok = credit_ok(inf_p_d, cl_p_d, cc_p_d, req_dcred_i);
        end else if (is_np) begin
            hdr_ok = credit_ok(inf_np_h, cl_np_h, cc_np_h, ONE);
        end else if (is_cpl) begin
            hdr_ok = credit_ok(inf_cpl_h, cl_cpl_h, cc_cpl_h, ONE);
            dat_ok = credit_ok(inf_cpl_d, cl_cpl_d, cc_cpl_d, req_dcred_i);
        end
        req_ready_o = (state == FC_ACTIVE) && req_valid_i && legal && hdr_ok && dat_ok;
        fc_err_o    = req_valid_i && !legal;
        if (!dl_up_i)
            state_nxt = FC_INIT;
        else if (state == FC_INIT && ep_cl_en_i)
            state_nxt = FC_ACTIVE;
    end

    assign xfer = req_valid_i && req_ready_o;

    always_ff @(posedge sclk or posedge srst) begin
        if (srst || !dl_up_i) begin
            {cl_p_h, cl_p_d, cl_np_h, cl_cpl_h, cl_cpl_d} <= '0;
            {cc_p_h, cc_p_d, cc_np_h, cc_cpl_h, cc_cpl_d} <= '0;
            {inf_p_h, inf_p_d, inf_np_h, inf_cpl_h, inf_cpl_d} <= '0;
        end else begin
            if (ep_cl_en_i) begin
                cl_p_h   <= ep_cl_p_h_i;
                cl_p_d   <= ep_cl_p_d_i;
                cl_np_h  <= ep_cl_np_h_i;
                cl_cpl_h <= ep_cl_cpl_h_i;
                cl_cpl_d <= ep_cl_cpl_d_i;
            end
            // Infinite-credit flags are latched only by the initial advertisement.
            if (ep_cl_en_i && state == FC_INIT) begin
                inf_p_h   <= (ep_cl_p_h_i == '0);
                inf_p_d   <= (ep_cl_p_d_i == '0);
                inf_np_h  <= (ep_cl_np_h_i == '0);
                inf_cpl_h <= (ep_cl_cpl_h_i == '0);
                inf_cpl_d <= (ep_cl_cpl_d_i == '0);
            end
            if (xfer && is_p) begin
                cc_p_h <= cc_p_h + ONE;
                cc_p_d <= cc_p_d + req_dcred_i;
            end
            if (xfer && is_np)
                cc_np_h <= cc_np_h + ONE;
            if (xfer && is_cpl) begin
                cc_cpl_h <= cc_cpl_h + ONE;
                cc_cpl_d <= cc_cpl_d + req_dcred_i;
            end
        end
    end

    assign tx_cc_p_h_o   = cc_p_h;
    assign tx_cc_p_d_o   = cc_p_d;
    assign tx_cc_np_h_o  = cc_np_h;
    assign tx_cc_cpl_h_o = cc_cpl_h;
    assign tx_cc_cpl_d_o = cc_cpl_d;
    assign fc_active_o   = (state == FC_ACTIVE);

endmodule
